// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the fetch-stage hazard/sequencing controller.
package pipe_ctrl_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int REG_W_DEF  = 5;
    localparam int REG_ZERO   = 0;

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        PEND        = 2'd1,
        TIMEOUT_ERR = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/stall_watchdog.sv
// Counts consecutive external-stall cycles and pulses expire on the cycle the run reaches MAX_STALL+1.
module stall_watchdog #(
    parameter int MAX_STALL = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic stall_req,
    output logic expire
);

    localparam int CNT_W = $clog2(MAX_STALL + 2);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_STALL);

    logic [CNT_W-1:0] run_cnt;

    // Saturates one past LIMIT so expire fires only once per run.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt <= '0;
        end else if (!stall_req) begin
            run_cnt <= '0;
        end else if (run_cnt <= LIMIT) begin
            run_cnt <= run_cnt + CNT_W'(1);
        end
    end

    assign expire = stall_req && (run_cnt == LIMIT);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Fetch-stage sequencing: load-use bubbles, external stalls, EX redirects held across stalls, stall watchdog.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int REG_W     = REG_W_DEF,
    parameter int MAX_STALL = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_redirect,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              ext_stall_req,
    output logic              stall,
    output logic              jump,
    output logic [ADDR_W-1:0] PC_mux,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              stall_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_flushes
`endif
);

    ctrl_state_t       st, st_next;
    logic [ADDR_W-1:0] pend_target, pend_next;
    logic              lu;
    logic              expire;

    stall_watchdog #(.MAX_STALL(MAX_STALL)) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .stall_req (ext_stall_req),
        .expire    (expire)
    );

    assign lu = ex_mem_read && (ex_rd != REG_W'(REG_ZERO)) &&
                ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_ff @(posedge clk) begin
        if (reset) begin
            st          <= RUN;
            pend_target <= '0;
        end else begin
            st          <= st_next;
            pend_target <= pend_next;
        end
    end

    always_comb begin
        st_next       = st;
        pend_next     = pend_target;
        stall         = 1'b0;
        jump          = 1'b0;
        PC_mux        = '0;
        flush_ifid    = 1'b0;
        flush_idex    = 1'b0;
        stall_timeout = 1'b0;
        case (st)
            RUN: begin
                if (ex_redirect && !ext_stall_req) begin
                    jump       = 1'b1;
                    PC_mux     = ex_target;
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                end else if (ex_redirect) begin
                    pend_next = ex_target;
                    stall     = 1'b1;
                    st_next   = PEND;
                end else if (ext_stall_req) begin
                    stall = 1'b1;
                end else if (lu) begin
                    stall      = 1'b1;
                    flush_idex = 1'b1;
                end
            end
            PEND: begin
                // EX is frozen here, so the live redirect inputs are a stale copy of pend_target.
                if (ext_stall_req) begin
                    stall = 1'b1;
                end else begin
                    jump       = 1'b1;
                    PC_mux     = pend_target;
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                    st_next    = RUN;
                end
            end
            TIMEOUT_ERR: begin
                stall         = 1'b1;
                stall_timeout = 1'b1;
            end
            default: st_next = RUN;
        endcase
        if (expire) begin
            st_next       = TIMEOUT_ERR;
            stall_timeout = 1'b1;
        end
        if (reset) begin
            stall         = 1'b0;
            jump          = 1'b0;
            PC_mux        = '0;
            flush_ifid    = 1'b0;
            flush_idex    = 1'b0;
            stall_timeout = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_flushes      <= '0;
        end else begin
            if (stall)      perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (flush_ifid) perf_flushes      <= perf_flushes + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed plus random bench for pipeline_hazard_ctrl, checked against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int ADDR_W    = 32;
    localparam int REG_W     = 5;
    localparam int MAX_STALL = 255;
    localparam int W         = ADDR_W + 5;
    localparam int M_RUN = 0, M_PEND = 1, M_ERR = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [REG_W-1:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic              id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
    logic              ex_mem_read = 1'b0, ex_redirect = 1'b0, ext_stall_req = 1'b0;
    logic [ADDR_W-1:0] ex_target = '0;
    logic              stall, jump, flush_ifid, flush_idex, stall_timeout;
    logic [ADDR_W-1:0] PC_mux;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]       perf_stall_cycles, perf_flushes;
`endif

    // clock / reset
    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.ADDR_W(ADDR_W), .REG_W(REG_W), .MAX_STALL(MAX_STALL)) dut (
        .clk           (clk),
        .reset         (reset),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_uses_rs1   (id_uses_rs1),
        .id_uses_rs2   (id_uses_rs2),
        .ex_rd         (ex_rd),
        .ex_mem_read   (ex_mem_read),
        .ex_redirect   (ex_redirect),
        .ex_target     (ex_target),
        .ext_stall_req (ext_stall_req),
        .stall         (stall),
        .jump          (jump),
        .PC_mux        (PC_mux),
        .flush_ifid    (flush_ifid),
        .flush_idex    (flush_idex),
        .stall_timeout (stall_timeout)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flushes      (perf_flushes)
`endif
    );

    // scoreboard and reference model state
    logic [W-1:0]      exp_q[$];
    int                tests = 0;
    int                fails = 0;
    int                m_mode = M_RUN;
    int                m_run = 0;
    logic [ADDR_W-1:0] m_pend = '0;
    int unsigned       m_stall_cnt = 0, m_flush_cnt = 0;

    task automatic idle();
        reset = 1'b0; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_redirect = 1'b0; ex_target = '0; ext_stall_req = 1'b0;
    endtask

    task automatic load_use(input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs2);
        ex_mem_read = 1'b1; ex_rd = rd; id_rs2 = rs2; id_uses_rs2 = 1'b1;
    endtask

    // One clock: model predicts this cycle's outputs from current inputs, compare, then advance on the edge.
    task automatic tick(input string tag);
        logic              e_stall, e_jump, e_fi, e_fx, e_to, lu_now;
        logic [ADDR_W-1:0] e_pc, nxt_pend;
        logic [W-1:0]      got, exp_v;
        int                cur_len, nxt_mode;
        #1;
        lu_now = ex_mem_read && (ex_rd != 0) &&
                 ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        cur_len  = ext_stall_req ? m_run + 1 : 0;
        {e_stall, e_jump, e_fi, e_fx, e_to} = 5'b0;
        e_pc     = '0;
        nxt_mode = m_mode;
        nxt_pend = m_pend;
        if (reset) begin
            nxt_mode = M_RUN; nxt_pend = '0; cur_len = 0;
        end else if (m_mode == M_ERR || cur_len > MAX_STALL) begin
            e_stall = 1'b1; e_to = 1'b1; nxt_mode = M_ERR;
        end else if (m_mode == M_PEND) begin
            if (ext_stall_req) e_stall = 1'b1;
            else begin
                e_jump = 1'b1; e_pc = m_pend; e_fi = 1'b1; e_fx = 1'b1; nxt_mode = M_RUN;
            end
        end else if (ex_redirect && !ext_stall_req) begin
            e_jump = 1'b1; e_pc = ex_target; e_fi = 1'b1; e_fx = 1'b1;
        end else if (ex_redirect) begin
            e_stall = 1'b1; nxt_pend = ex_target; nxt_mode = M_PEND;
        end else if (ext_stall_req) begin
            e_stall = 1'b1;
        end else if (lu_now) begin
            e_stall = 1'b1; e_fx = 1'b1;
        end
        exp_q.push_back({e_stall, e_jump, e_fi, e_fx, e_to, e_pc});
        got   = {stall, jump, flush_ifid, flush_idex, stall_timeout, PC_mux};
        exp_v = exp_q.pop_front();
        tests++;
        assert (got === exp_v) else begin
            fails++;
            $error("FAIL %s: observed stall/jump/fi/fx/to/pc=%b%b%b%b%b/%h required=%b%b%b%b%b/%h",
                   tag, got[W-1], got[W-2], got[W-3], got[W-4], got[W-5], got[ADDR_W-1:0],
                   exp_v[W-1], exp_v[W-2], exp_v[W-3], exp_v[W-4], exp_v[W-5], exp_v[ADDR_W-1:0]);
        end
        @(posedge clk);
        if (reset) begin
            m_stall_cnt = 0; m_flush_cnt = 0;
        end else begin
            if (e_stall) m_stall_cnt++;
            if (e_fi)    m_flush_cnt++;
        end
        m_mode = nxt_mode; m_pend = nxt_pend; m_run = cur_len;
        #1;
    endtask

    initial begin
        @(posedge clk); #1;
        // reset forces outputs low even with a redirect presented
        idle(); reset = 1'b1; ex_redirect = 1'b1; ex_target = 32'h40;
        tick("reset_out"); tick("reset_out2");

        idle(); load_use(5'd5, 5'd5);
        tick("lu_bubble");
        ex_mem_read = 1'b0; tick("lu_after_bubble");
        idle(); load_use(5'd0, 5'd0); tick("lu_rd_zero");

        idle(); ex_redirect = 1'b1; ex_target = 32'h40;
        tick("redirect_now");

        idle(); ex_redirect = 1'b1; ex_target = 32'h80; ext_stall_req = 1'b1;
        for (int i = 0; i < 3; i++) tick("pend_stall");
        ext_stall_req = 1'b0; tick("pend_release");
        idle(); tick("pend_done");

        idle(); ex_redirect = 1'b1; ex_target = 32'hC0; load_use(5'd7, 5'd7);
        tick("redirect_over_lu");

        idle(); ext_stall_req = 1'b1; load_use(5'd3, 5'd3);
        tick("ext_with_lu");
        ext_stall_req = 1'b0; tick("lu_after_ext");
        idle(); tick("idle");

        // reset while a redirect is pending must drop it
        idle(); ex_redirect = 1'b1; ex_target = 32'h100; ext_stall_req = 1'b1;
        tick("pend_enter"); tick("pend_hold");
        reset = 1'b1; tick("reset_in_pend");
        idle(); tick("no_jump_after_reset"); tick("no_jump_after_reset2");

        for (int i = 0; i < 400; i++) begin
            reset         = ($urandom_range(0, 59) == 0);
            ext_stall_req = ($urandom_range(0, 3) == 0);
            ex_redirect   = ($urandom_range(0, 3) == 0);
            ex_target     = $urandom;
            ex_mem_read   = $urandom_range(0, 1);
            ex_rd         = REG_W'($urandom_range(0, 3));
            id_rs1        = REG_W'($urandom_range(0, 3));
            id_rs2        = REG_W'($urandom_range(0, 3));
            id_uses_rs1   = $urandom_range(0, 1);
            id_uses_rs2   = $urandom_range(0, 1);
            tick("random");
        end

        idle(); reset = 1'b1; tick("reset_pre_wd");
        idle(); ext_stall_req = 1'b1;
        for (int i = 0; i < MAX_STALL + 1; i++) tick("watchdog_run");
        ext_stall_req = 1'b0; ex_redirect = 1'b1; ex_target = 32'h44;
        for (int i = 0; i < 3; i++) tick("timeout_sticky");
        reset = 1'b1; tick("reset_clears_err");
        idle(); ex_redirect = 1'b1; ex_target = 32'h48;
        tick("redirect_after_err");
        idle(); tick("final_idle");

`ifdef HAZARD_PERF_CNT_EN
        tests++;
        assert (perf_stall_cycles === m_stall_cnt) else begin
            fails++;
            $error("FAIL perf_stall: observed=%0d required=%0d", perf_stall_cycles, m_stall_cnt);
        end
        tests++;
        assert (perf_flushes === m_flush_cnt) else begin
            fails++;
            $error("FAIL perf_flush: observed=%0d required=%0d", perf_flushes, m_flush_cnt);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
